// File: rtl/powlib_pipe.sv
// -----------------------------------------------------------------------------
// powlib_pipe
//
// Parametrised D-stage registered pipeline with valid/ready flow control.
// Each stage holds one data word and one valid bit. Stages collapse bubbles:
// an empty stage always loads, even while the output is stalled, so the pipe
// buffers exactly D beats before it deasserts rdy.
//
// Handshake rule (both sides): a beat transfers on a rising edge where
// valid and ready are both 1. A producer holding valid=1 while ready=0 keeps
// its data and valid stable until the transfer happens. The ready chain is
// combinational, so a full pipe that is popping this cycle also accepts.
//
// Parameters
//   W    : data width in bits (>= 1)
//   D    : number of register stages (>= 1)
//   INIT : reset value of every stage data register
//   EBP  : 1 = honour qrdy; 0 = treat qrdy as always 1 (plain valid shift)
//
// Ports
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous active-high reset
//   clr  : synchronous flush of every valid bit (data registers hold)
//   d    : input data
//   vld  : input beat valid
//   rdy  : pipe accepts a beat this cycle (combinational)
//   q    : output data, last stage register
//   qvld : output beat valid, last stage valid register
//   qrdy : downstream accepts the output beat
//   cnt  : number of occupied stages, registered
// -----------------------------------------------------------------------------
module powlib_pipe #(
    parameter int unsigned     W    = 1,
    parameter int unsigned     D    = 2,
    parameter logic [W-1:0]    INIT = '0,
    parameter bit              EBP  = 1'b1,
    localparam int unsigned    CW   = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [W-1:0]  d,
    input  logic          vld,
    output logic          rdy,
    output logic [W-1:0]  q,
    output logic          qvld,
    input  logic          qrdy,
    output logic [CW-1:0] cnt
);

    // Stage state: v_q[i] is the valid bit of stage i, r_q[i] its data.
    logic [D-1:0]  v_q;
    logic [D-1:0]  v_d;
    logic [W-1:0]  r_q [D];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // en[i]  : stage i may load this edge (empty, or its beat moves on)
    // adv[i] : the beat in stage i moves on this edge
    // ld[i]  : stage i captures a valid beat this edge (data register load)
    logic [D-1:0]  en;
    logic [D-1:0]  adv;
    logic [D-1:0]  ld;
    logic          qrdy_eff;

    // -------------------------------------------------------------------------
    // Ready / advance chain. Evaluated from the output stage backwards so
    // that a pop at the end frees every full stage in front of it in the
    // same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        qrdy_eff = EBP ? qrdy : 1'b1;
        adv      = '0;
        en       = '0;
        adv[D-1] = v_q[D-1] & qrdy_eff;
        en[D-1]  = ~v_q[D-1] | adv[D-1];
        for (int i = int'(D) - 2; i >= 0; i--) begin
            adv[i] = v_q[i] & en[i+1];
            en[i]  = ~v_q[i] | adv[i];
        end
    end

    // -------------------------------------------------------------------------
    // Next valid bits, data load enables and next occupancy.
    // -------------------------------------------------------------------------
    always_comb begin
        v_d = v_q;
        ld  = '0;
        if (en[0]) begin
            v_d[0] = vld;
            ld[0]  = vld;
        end
        for (int i = 1; i < int'(D); i++) begin
            if (en[i]) begin
                v_d[i] = v_q[i-1];
                ld[i]  = v_q[i-1];
            end
        end
        cnt_d = '0;
        for (int i = 0; i < int'(D); i++) begin
            cnt_d = cnt_d + CW'(v_d[i]);
        end
    end

    // -------------------------------------------------------------------------
    // Valid bits and occupancy. clr wins over any accept or pop.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            cnt_q <= '0;
        end else if (clr) begin
            v_q   <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            cnt_q <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Data registers. A register only loads when a valid beat enters it, so
    // an empty stage keeps its previous contents; clr leaves data untouched.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q[0] <= INIT;
        end else if (!clr && ld[0]) begin
            r_q[0] <= d;
        end
    end

    for (genvar g = 1; g < int'(D); g++) begin : g_stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_q[g] <= INIT;
            end else if (!clr && ld[g]) begin
                r_q[g] <= r_q[g-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. rdy is forced low during clr (the beat would be discarded)
    // and during rst (no state can change).
    // -------------------------------------------------------------------------
    assign rdy  = en[0] & ~clr & ~rst;
    assign q    = r_q[D-1];
    assign qvld = v_q[D-1];
    assign cnt  = cnt_q;

endmodule

// File: tb/tb_powlib_pipe.sv
module tb_powlib_pipe;

  localparam int unsigned W    = 8;
  localparam int unsigned D    = 3;
  localparam logic [W-1:0] INIT = 8'hA5;
  localparam int unsigned CW   = $clog2(D + 1);

  // ---------------------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------------------
  logic          clk;
  logic          rst;
  logic          clr;
  logic [W-1:0]  d;
  logic          vld;
  logic          rdy;
  logic [W-1:0]  q;
  logic          qvld;
  logic          qrdy;
  logic [CW-1:0] cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  powlib_pipe #(
    .W    (W),
    .D    (D),
    .INIT (INIT),
    .EBP  (1'b1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .d    (d),
    .vld  (vld),
    .rdy  (rdy),
    .q    (q),
    .qvld (qvld),
    .qrdy (qrdy),
    .cnt  (cnt)
  );

  // ---------------------------------------------------------------------------
  // scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // driver: one cycle. Called at a falling edge; drives inputs, checks the
  // combinational ready and any output beat, then advances to the next
  // falling edge and checks the occupancy.
  // ---------------------------------------------------------------------------
  task automatic step(input logic v_in, input logic [W-1:0] d_in,
                      input logic qr_in, input logic clr_in, output logic acc);
    logic exp_rdy;
    logic [W-1:0] front;
    vld  = v_in;
    d    = d_in;
    qrdy = qr_in;
    clr  = clr_in;
    #1;
    exp_rdy = !clr_in && ((exp_q.size() < D) || qr_in);
    chk("rdy", {31'd0, rdy}, {31'd0, exp_rdy});
    if (!clr_in && qvld && qr_in) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {24'd0, q}, 32'hFFFF_FFFF);
      end else begin
        front = exp_q.pop_front();
        chk("q_data", {24'd0, q}, {24'd0, front});
      end
    end
    acc = !clr_in && v_in && rdy;
    if (acc) exp_q.push_back(d_in);
    if (clr_in) exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("cnt", {{(32-CW){1'b0}}, cnt}, exp_q.size());
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0, a);
    chk("drained", exp_q.size(), 0);
    chk("drained_qvld", {31'd0, qvld}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic a;
    logic hv;
    logic v_r;
    logic [W-1:0] d_r;

    rst = 1'b1; clr = 1'b0; d = '0; vld = 1'b0; qrdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_q", {24'd0, q}, {24'd0, INIT});
    chk("rst_qvld", {31'd0, qvld}, 32'd0);
    chk("rst_cnt", {{(32-CW){1'b0}}, cnt}, 32'd0);
    chk("rst_rdy", {31'd0, rdy}, 32'd0);
    rst = 1'b0;

    // streaming: 1..5 back to back, 3-cycle latency, no gaps
    for (int k = 0; k < 8; k++) begin
      step(k < 5, W'(k + 1), 1'b1, 1'b0, a);
      chk("stream_qvld", {31'd0, qvld}, {31'd0, (k >= 2 && k <= 6)});
      if (k >= 2 && k <= 6) chk("stream_q", {24'd0, q}, k - 1);
    end
    drain();

    // backpressure fill: 10,11,12 buffered, 13 refused until a pop
    step(1'b1, 8'd10, 1'b0, 1'b0, a);
    step(1'b1, 8'd11, 1'b0, 1'b0, a);
    step(1'b1, 8'd12, 1'b0, 1'b0, a);
    step(1'b1, 8'd13, 1'b0, 1'b0, a);
    chk("bp_refused", {31'd0, a}, 32'd0);
    chk("bp_hold_q", {24'd0, q}, 32'd10);
    chk("bp_hold_qvld", {31'd0, qvld}, 32'd1);
    step(1'b1, 8'd13, 1'b1, 1'b0, a);
    chk("bp_reaccept", {31'd0, a}, 32'd1);
    drain();

    // bubble collapse: only the last stage valid, then 8 and 9 under stall
    step(1'b1, 8'd7, 1'b0, 1'b0, a);
    step(1'b0, 8'd0, 1'b0, 1'b0, a);
    step(1'b0, 8'd0, 1'b0, 1'b0, a);
    chk("bub_q", {24'd0, q}, 32'd7);
    step(1'b1, 8'd8, 1'b0, 1'b0, a);
    chk("bub_acc8", {31'd0, a}, 32'd1);
    step(1'b1, 8'd9, 1'b0, 1'b0, a);
    chk("bub_acc9", {31'd0, a}, 32'd1);
    drain();

    // full with simultaneous pop
    step(1'b1, 8'd20, 1'b0, 1'b0, a);
    step(1'b1, 8'd21, 1'b0, 1'b0, a);
    step(1'b1, 8'd22, 1'b0, 1'b0, a);
    step(1'b1, 8'd23, 1'b1, 1'b0, a);
    chk("full_pop_acc", {31'd0, a}, 32'd1);
    chk("full_pop_cnt", {{(32-CW){1'b0}}, cnt}, 32'd3);
    drain();

    // flush with a beat presented during clr
    step(1'b1, 8'd30, 1'b0, 1'b0, a);
    step(1'b1, 8'd31, 1'b0, 1'b0, a);
    step(1'b1, 8'd32, 1'b0, 1'b0, a);
    step(1'b1, 8'd99, 1'b1, 1'b1, a);
    chk("clr_qvld", {31'd0, qvld}, 32'd0);
    chk("clr_cnt", {{(32-CW){1'b0}}, cnt}, 32'd0);
    drain();

    // random traffic, upstream holds a refused beat stable
    hv = 1'b0; v_r = 1'b0; d_r = '0;
    for (int i = 0; i < 300; i++) begin
      if (!hv) begin
        v_r = 1'($urandom_range(0, 1));
        d_r = W'($urandom_range(0, 255));
      end
      step(v_r, d_r, ($urandom_range(0, 3) != 0), 1'b0, a);
      hv = v_r && !a;
    end
    drain();

    // asynchronous reset mid-stream
    step(1'b1, 8'd50, 1'b0, 1'b0, a);
    step(1'b1, 8'd51, 1'b0, 1'b0, a);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_q", {24'd0, q}, {24'd0, INIT});
    chk("arst_qvld", {31'd0, qvld}, 32'd0);
    chk("arst_cnt", {{(32-CW){1'b0}}, cnt}, 32'd0);
    chk("arst_rdy", {31'd0, rdy}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'd40, 1'b1, 1'b0, a);
    chk("post_rst_acc", {31'd0, a}, 32'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/powlib_pipe.md
Name: powlib_pipe

Overview:
Parametrised D-stage registered pipeline. Each stage carries a data word and a valid bit, and a ready chain provides backpressure. Stages collapse bubbles: an empty stage always accepts, even when downstream is stalled. It is the multi-stage, flow-controlled successor to the single-stage valid flip-flop, and is used to retime long paths between powlib handshake blocks without losing beats.

Parameters:
W, 1, data width in bits (>=1)
D, 2, number of register stages (>=1)
INIT, 0 (W bits), reset value of every stage data register
EBP, 1, enable backpressure; 0 ties internal qrdy to 1 (plain valid shift pipe, rdy constantly 1 outside clr)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous flush of all valid bits
d  input  W  input data
vld  input  1  input beat valid
rdy  output  1  pipe accepts a beat this cycle (combinational)
q  output  W  output data (last stage register)
qvld  output  1  output beat valid (last stage valid register)
qrdy  input  1  downstream accepts the beat; ignored when EBP=0
cnt  output  clog2(D+1)  number of occupied stages

Behaviour:
- Reset: clk is single clock; rst asynchronous active-high. While rst=1, all stage data = INIT, all valid bits = 0, so q=INIT, qvld=0, cnt=0, rdy=0. rdy is held at 0 during rst.
- Stage indexing: stage 0 is the input stage, stage D-1 drives q/qvld. v[i] is the valid bit and r[i] the data register of stage i.
- Advance terms:
  - adv[D-1] = qvld & qrdy_eff, where qrdy_eff = EBP ? qrdy : 1.
  - en[i] = !v[i] | adv[i] (stage i may load).
  - adv[i] = v[i] & en[i+1] for i < D-1.
  - rdy = en[0] & !clr & !rst.
- Stage update each rising edge (clr=0):
  - Stage 0: if en[0], then v[0] <= vld; r[0] <= d only when vld=1.
  - Stage i>0: if en[i], then v[i] <= v[i-1]; r[i] <= r[i-1] only when v[i-1]=1.
  - Data registers never load invalid data; a stage's data holds while it is empty.
- Latency: with no stall, a beat accepted at edge N appears with qvld=1 at edge N+D-1, i.e. D cycles of register delay from d to q. Throughput is 1 beat/cycle when qrdy=1.
- Stall: qvld=1 with qrdy=0 holds q and qvld stable, which satisfies the standard valid/ready hold rule. Upstream stages keep filling until every stage is valid. At that point rdy=0. Exactly D beats are buffered and none are dropped or duplicated.
- Full with simultaneous pop: when all stages are valid and qrdy=1, rdy=1 the same cycle (combinational ready chain). Accept and pop occur together and cnt is unchanged.
- Upstream must hold d and vld stable while vld=1 and rdy=0.
- clr=1: on the next edge all v[i] <= 0, and data registers hold. An input beat presented during clr is discarded; rdy=0 during clr so no transfer is signalled. clr has priority over every simultaneous accept or pop.
- cnt: population count of v[]; registered, updated the same edge as v[].
- rst asserted mid-operation: immediate asynchronous return to reset state and all in-flight beats are lost. On release, normal operation resumes on the first edge after deassertion.
- D=1: single stage with en = !qvld | qrdy_eff, which gives a half-rate-free, full-throughput single buffer.

Test Plan:
- Reset: W=8, D=3, INIT=8'hA5; assert rst mid-stream -> q=8'hA5, qvld=0, cnt=0, rdy=0 immediately without waiting for a clk edge.
- Streaming: qrdy=1, drive vld=1 with d=1,2,3,4,5 on consecutive cycles -> q=1..5 on qvld with exactly 3-cycle latency and no gaps.
- Backpressure fill: qrdy=0, push d=10,11,12,13 -> first three accepted, rdy=0 on the 4th with cnt=3. Release qrdy -> q sequence 10,11,12, then 13 once re-accepted; no loss or duplication.
- Bubble collapse: qrdy=0, with only stage D-1 valid (d=7), push 8 and 9 -> both accepted on consecutive cycles and cnt goes 1,2,3.
- Full with simultaneous pop: D=3 full with 20,21,22, qrdy=1, vld=1, d=23 -> rdy=1, 20 popped, 23 accepted, cnt stays 3.
- Flush: pipe holds 3 beats, clr=1 for one cycle with vld=1, d=99 -> next edge qvld=0, cnt=0, rdy=0 during clr, and 99 never appears on q.
